// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage feeding the serial run detector. Words arrive over a
// valid/ready handshake and leave one bit per clock on ser_bit, qualified by
// ser_valid. A one-word holding register lets back-to-back words stream with
// no idle cycle between them.
//
// Parameters:
//   DATA_W     word width in bits (>= 2)
//   LSB_FIRST  0: MSB transmitted first, 1: LSB transmitted first
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    parallel word, sampled only on an accept edge
//   in_valid   upstream word available
//   in_ready   block can take a word this cycle
//   ser_bit    current serial bit (0 when idle)
//   ser_valid  ser_bit carries a real data bit this cycle
//   ser_last   ser_bit is the final bit of the current word
//   busy       shifter active or holding register occupied
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q,  hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              accept;
  logic              at_last;

  // Ready depends only on registered state and reset, never on in_valid, so
  // upstream may legally wait for in_ready before raising in_valid.
  assign in_ready = !hold_full_q && !rst;
  assign accept   = in_valid && in_ready;
  assign at_last  = (cnt_q == LAST_CNT);

  // Moves the next bit to be transmitted onto the output end of the register.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
    if (LSB_FIRST) shift_one = {1'b0, v[DATA_W-1:1]};
    else           shift_one = {v[DATA_W-2:0], 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  // NOTE: the holding register is reset along with the control bits; a stale
  // word behind a cleared hold_full flag would be harmless, but a fully reset
  // datapath keeps post-reset behaviour identical from run to run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; without it some path
  // through the case would leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (!at_last) begin
          shreg_d = shift_one(shreg_q);
          cnt_d   = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Word boundary with a word waiting: hand it over with no gap.
          // in_ready is low here, so no new word can collide with the move.
          shreg_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word boundary with an empty hold: bypass straight into the shifter.
          shreg_d = in_data;
          cnt_d   = '0;
        end else begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only, no path from in_* to ser_*)
  // ---------------------------------------------------------------------------
  always_comb begin
    ser_valid = (state_q == SHIFT);
    ser_last  = (state_q == SHIFT) && at_last;
    busy      = (state_q == SHIFT) || hold_full_q;
    ser_bit   = 1'b0;
    if (state_q == SHIFT) begin
      ser_bit = LSB_FIRST ? shreg_q[0] : shreg_q[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for bit_serializer. Two instances share clock, reset and input
// stimulus: one transmits MSB first, the other LSB first. A word-level model
// (current word + bit index + queue of waiting words) predicts every output
// each cycle; scenario tasks add directed checks on top.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;

  logic in_ready0, ser_bit0, ser_valid0, ser_last0, busy0;
  logic in_ready1, ser_bit1, ser_valid1, ser_last1, busy1;

  bit_serializer #(.DATA_W(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .ser_bit   (ser_bit0),
    .ser_valid (ser_valid0),
    .ser_last  (ser_last0),
    .busy      (busy0)
  );

  bit_serializer #(.DATA_W(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .ser_bit   (ser_bit1),
    .ser_valid (ser_valid1),
    .ser_last  (ser_last1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the word being transmitted, which bit of it is on the
  // wire, and the words accepted but not yet started.
  logic         m_active;
  logic [W-1:0] m_word;
  int           m_idx;
  logic [W-1:0] m_q[$];

  // Values sampled during the most recent step.
  logic s_bit0, s_bit1, s_valid0, s_valid1, s_last0, s_last1, s_ready0, s_busy0;
  logic s_acc;

  // MSB-first words reassembled from the serial stream.
  logic [W-1:0] asm0;
  logic [W-1:0] obs0[$];

  task automatic model_reset();
    m_active = 1'b0;
    m_word   = '0;
    m_idx    = 0;
    m_q.delete();
    asm0     = '0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare both instances
  // with the model, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input string tag);
    logic [4:0] exp0, exp1, got0, got1;
    logic       e_ready, e_bit0, e_bit1, e_last, e_busy;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    e_ready  = (m_q.size() == 0);
    e_bit0   = m_active ? m_word[W-1-m_idx] : 1'b0;
    e_bit1   = m_active ? m_word[m_idx]     : 1'b0;
    e_last   = m_active && (m_idx == W-1);
    e_busy   = m_active || (m_q.size() != 0);
    exp0 = {e_ready, m_active, e_bit0, e_last, e_busy};
    exp1 = {e_ready, m_active, e_bit1, e_last, e_busy};
    got0 = {in_ready0, ser_valid0, ser_bit0, ser_last0, busy0};
    got1 = {in_ready1, ser_valid1, ser_bit1, ser_last1, busy1};
    vectors++;
    if (got0 !== exp0) begin
      $display("FAIL %s msb {ready,valid,bit,last,busy} got %b want %b at %0t", tag, got0, exp0, $time);
      miscompares++;
    end
    vectors++;
    if (got1 !== exp1) begin
      $display("FAIL %s lsb {ready,valid,bit,last,busy} got %b want %b at %0t", tag, got1, exp1, $time);
      miscompares++;
    end
    s_bit0 = ser_bit0;  s_bit1 = ser_bit1;
    s_valid0 = ser_valid0; s_valid1 = ser_valid1;
    s_last0 = ser_last0; s_last1 = ser_last1;
    s_ready0 = in_ready0; s_busy0 = busy0;
    s_acc = v && e_ready;
    if (ser_valid0) begin
      asm0 = {asm0[W-2:0], ser_bit0};
      if (ser_last0) obs0.push_back(asm0);
    end
    @(posedge clk);
    if (m_active) begin
      if (m_idx == W-1) m_active = 1'b0;
      else              m_idx++;
    end
    if (!m_active) begin
      if (m_q.size() != 0) begin
        m_word = m_q.pop_front(); m_idx = 0; m_active = 1'b1;
      end else if (s_acc) begin
        m_word = d; m_idx = 0; m_active = 1'b1;
      end
    end else if (s_acc) begin
      m_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;       // must be ignored while in reset
    in_data  = 8'hAA;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready0, ser_valid0, ser_bit0, ser_last0, busy0} !== 5'b0) begin
      $display("FAIL reset_msb outputs got %b want 00000",
               {in_ready0, ser_valid0, ser_bit0, ser_last0, busy0});
      miscompares++;
    end
    vectors++;
    if ({in_ready1, ser_valid1, ser_bit1, ser_last1, busy1} !== 5'b0) begin
      $display("FAIL reset_lsb outputs got %b want 00000",
               {in_ready1, ser_valid1, ser_bit1, ser_last1, busy1});
      miscompares++;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      $display("FAIL reset_release in_ready got %b want 11", {in_ready0, in_ready1});
      miscompares++;
    end
    repeat (2) step(1'b0, 8'h00, "reset_idle");
  endtask

  task automatic test_single_word();
    logic [W-1:0] bits, lasts;
    logic         all_valid;
    bits = '0; lasts = '0; all_valid = 1'b1;
    step(1'b1, 8'hA5, "t1_accept");
    for (int i = 0; i < W; i++) begin
      step(1'b0, 8'h00, "t1_bit");
      bits  = {bits[W-2:0], s_bit0};
      lasts = {lasts[W-2:0], s_last0};
      all_valid &= s_valid0;
    end
    vectors++;
    if (bits !== 8'hA5 || !all_valid) begin
      $display("FAIL t1_bits got %h valid %b want a5 valid 1", bits, all_valid);
      miscompares++;
    end
    vectors++;
    if (lasts !== 8'h01) begin
      $display("FAIL t1_last_pos got %b want 00000001", lasts);
      miscompares++;
    end
    step(1'b0, 8'h00, "t1_idle");
    vectors++;
    if ({s_valid0, s_bit0, s_busy0} !== 3'b000) begin
      $display("FAIL t1_after {valid,bit,busy} got %b want 000", {s_valid0, s_bit0, s_busy0});
      miscompares++;
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] words[3];
    logic [23:0]  got0, got1, last_mask;
    int           idx, n, ready_low;
    logic         ended, gap;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h0F;
    got0 = '0; got1 = '0; last_mask = '0;
    idx = 0; n = 0; ready_low = 0; ended = 1'b0; gap = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(idx < 3, (idx < 3) ? words[idx] : 8'h00, "t2_stream");
      if (!s_ready0) ready_low++;
      if (s_acc) idx++;
      if (s_valid0) begin
        if (ended) gap = 1'b1;
        got0 = {got0[22:0], s_bit0};
        got1 = {got1[22:0], s_bit1};
        last_mask = {last_mask[22:0], s_last0};
        n++;
      end else if (n > 0) begin
        ended = 1'b1;
      end
    end
    vectors++;
    if (n != 24 || gap || idx != 3) begin
      $display("FAIL t2_duty bits %0d gap %b accepted %0d want 24 0 3", n, gap, idx);
      miscompares++;
    end
    vectors++;
    if (got0 !== 24'hFF000F || got1 !== 24'hFF00F0) begin
      $display("FAIL t2_data msb %h lsb %h want ff000f ff00f0", got0, got1);
      miscompares++;
    end
    vectors++;
    if (last_mask !== 24'h010101) begin
      $display("FAIL t2_last_pos got %h want 010101", last_mask);
      miscompares++;
    end
    vectors++;
    if (ready_low != 14) begin
      $display("FAIL t2_ready_low cycles got %0d want 14", ready_low);
      miscompares++;
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] bits, lasts;
    bits = '0; lasts = '0;
    step(1'b1, 8'h01, "t3_accept");
    for (int i = 0; i < W; i++) begin
      step(1'b0, 8'h00, "t3_bit");
      bits  = {bits[W-2:0], s_bit1};
      lasts = {lasts[W-2:0], s_last1};
    end
    vectors++;
    if (bits !== 8'h80 || lasts !== 8'h01) begin
      $display("FAIL t3_lsb_order bits %b last %b want 10000000 00000001", bits, lasts);
      miscompares++;
    end
    step(1'b0, 8'h00, "t3_idle");
  endtask

  task automatic test_hold_block();
    int   blocked;
    logic taken;
    blocked = 0; taken = 1'b0;
    obs0.delete();
    step(1'b1, 8'h11, "t4_first");
    step(1'b1, 8'h22, "t4_hold");
    for (int c = 0; c < 20 && !taken; c++) begin
      step(1'b1, 8'h3C, "t4_present");
      if (s_acc) taken = 1'b1;
      else if (!s_ready0) blocked++;
    end
    vectors++;
    if (!taken || blocked != 7) begin
      $display("FAIL t4_blocked taken %b blocked %0d want 1 7", taken, blocked);
      miscompares++;
    end
    repeat (20) step(1'b0, 8'h00, "t4_drain");
    vectors++;
    if (obs0.size() != 3) begin
      $display("FAIL t4_word_count got %0d want 3", obs0.size());
      miscompares++;
    end else if (obs0[0] !== 8'h11 || obs0[1] !== 8'h22 || obs0[2] !== 8'h3C) begin
      $display("FAIL t4_words got %h %h %h want 11 22 3c", obs0[0], obs0[1], obs0[2]);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    int seen;
    seen = 0;
    step(1'b1, 8'hC3, "t5_accept");
    step(1'b0, 8'h00, "t5_bit1");
    step(1'b0, 8'h00, "t5_bit2");
    // Now inside the bit-3 cycle: assert reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({ser_valid0, ser_bit0, busy0, in_ready0, ser_valid1, busy1} !== 6'b0) begin
      $display("FAIL t5_async_drop got %b want 000000",
               {ser_valid0, ser_bit0, busy0, in_ready0, ser_valid1, busy1});
      miscompares++;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready0 !== 1'b1) begin
      $display("FAIL t5_ready_after got %b want 1", in_ready0);
      miscompares++;
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h00, "t5_quiet");
      if (s_valid0 || s_valid1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      $display("FAIL t5_no_resume valid cycles got %0d want 0", seen);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    int          n;
    logic        ended, gap, last_at_accept;
    bits = '0; n = 0; ended = 1'b0; gap = 1'b0; last_at_accept = 1'b0;
    step(1'b1, 8'h7E, "t6_accept");
    for (int i = 0; i < 18; i++) begin
      step(i == 7, (i == 7) ? 8'h81 : 8'h00, "t6_stream");
      if (i == 7) last_at_accept = s_last0 && s_acc;
      if (s_valid0) begin
        if (ended) gap = 1'b1;
        bits = {bits[14:0], s_bit0};
        n++;
      end else if (n > 0) begin
        ended = 1'b1;
      end
    end
    vectors++;
    if (!last_at_accept) begin
      $display("FAIL t6_accept_on_last got %b want 1", last_at_accept);
      miscompares++;
    end
    vectors++;
    if (bits !== 16'h7E81 || n != 16 || gap) begin
      $display("FAIL t6_gapless bits %h count %0d gap %b want 7e81 16 0", bits, n, gap);
      miscompares++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), "rand");
    end
    repeat (20) step(1'b0, 8'h00, "rand_drain");
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_single_word();
    test_stream();
    test_lsb_first();
    test_hold_block();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
